// File: rtl/alu_pkg.sv
// Shared opcode/state types and helpers for the pipelined ALU.
package alu_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_XOR   = 4'd2,
        OP_RXOR  = 4'd3,
        OP_CMPHI = 4'd4,
        OP_SHL   = 4'd5,
        OP_SHR   = 4'd6,
        OP_PASS  = 4'd7,
        OP_AND   = 4'd8,
        OP_OR    = 4'd9,
        OP_ASR   = 4'd10
    } op_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic logic is_shift(op_t op);
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ASR);
    endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ALU operations. Shift opcodes pass a through, which is exactly
// the result wanted for a zero-length shift.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CMP_MSBS = 5
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res,
    output logic             carry
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic           hi_eq;

    assign sum   = {1'b0, a} + {1'b0, b};
    assign diff  = {1'b0, a} - {1'b0, b};
    assign hi_eq = (a[WIDTH-1 -: CMP_MSBS] == b[WIDTH-1 -: CMP_MSBS]);

    always_comb begin
        res   = a;
        carry = 1'b0;
        case (op)
            OP_ADD: begin
                res   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
            end
            OP_SUB: begin
                // No borrow out of the extended subtraction means a >= b.
                res   = diff[WIDTH-1:0];
                carry = ~diff[WIDTH];
            end
            OP_XOR:   res = a ^ b;
            OP_RXOR:  res = {{(WIDTH-1){1'b0}}, ^a};
            OP_CMPHI: res = {{(WIDTH-1){1'b0}}, hi_eq};
            OP_AND:   res = a & b;
            OP_OR:    res = a | b;
            default:  res = a;
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes; shifts iterate one bit per cycle.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CMP_MSBS = 5
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             busy
);

    localparam int               CNT_W   = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] WIDTH_B = WIDTH[WIDTH-1:0];
    localparam logic [CNT_W-1:0] K_MAX   = WIDTH[CNT_W-1:0];

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [WIDTH-1:0]  sh_reg;
    logic [OP_W-1:0]   sh_op_reg;
    logic [WIDTH-1:0]  result_reg;
    logic              zero_reg;
    logic              carry_reg;
    logic              out_valid_reg;

    logic [WIDTH-1:0]  core_res;
    logic              core_carry;
    logic [CNT_W-1:0]  k;
    logic              accept;
    logic              xfer;
    logic              shift_start;
    logic [WIDTH-1:0]  shl_next, shr_next, asr_next, sh_next;

    alu_comb_core #(
        .WIDTH    (WIDTH),
        .CMP_MSBS (CMP_MSBS)
    ) u_core (
        .op    (op),
        .a     (a),
        .b     (b),
        .res   (core_res),
        .carry (core_carry)
    );

    assign in_ready    = (state_reg == IDLE) && (!out_valid_reg || out_ready);
    assign accept      = in_valid && in_ready;
    assign xfer        = out_valid_reg && out_ready;
    assign k           = (b >= WIDTH_B) ? K_MAX : b[CNT_W-1:0];
    assign shift_start = is_shift(op_t'(op)) && (k != '0);

    // One-bit step of each shift flavour, built per bit position.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_step
        if (gi == 0) begin : g_lsb
            assign shl_next[gi] = 1'b0;
            assign shr_next[gi] = sh_reg[gi+1];
            assign asr_next[gi] = sh_reg[gi+1];
        end else if (gi == WIDTH - 1) begin : g_msb
            assign shl_next[gi] = sh_reg[gi-1];
            assign shr_next[gi] = 1'b0;
            assign asr_next[gi] = sh_reg[gi];
        end else begin : g_mid
            assign shl_next[gi] = sh_reg[gi-1];
            assign shr_next[gi] = sh_reg[gi+1];
            assign asr_next[gi] = sh_reg[gi+1];
        end
    end

    always_comb begin
        sh_next = shr_next;
        case (sh_op_reg)
            OP_SHL:  sh_next = shl_next;
            OP_ASR:  sh_next = asr_next;
            default: sh_next = shr_next;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept && shift_start) state_next = SHIFT;
            SHIFT:   if (cnt_reg == CNT_W'(1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_reg       <= '0;
            sh_reg        <= '0;
            sh_op_reg     <= OP_ADD;
            result_reg    <= '0;
            zero_reg      <= 1'b0;
            carry_reg     <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept && shift_start) begin
                        // Accept implies any held result is leaving this edge.
                        sh_reg        <= a;
                        cnt_reg       <= k;
                        sh_op_reg     <= op;
                        out_valid_reg <= 1'b0;
                    end else if (accept) begin
                        result_reg    <= core_res;
                        zero_reg      <= (core_res == '0);
                        carry_reg     <= core_carry;
                        out_valid_reg <= 1'b1;
                    end else if (xfer) begin
                        out_valid_reg <= 1'b0;
                    end
                end
                SHIFT: begin
                    sh_reg  <= sh_next;
                    cnt_reg <= cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) begin
                        result_reg    <= sh_next;
                        zero_reg      <= (sh_next == '0);
                        carry_reg     <= 1'b0;
                        out_valid_reg <= 1'b1;
                    end
                end
                default: out_valid_reg <= 1'b0;
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign zero      = zero_reg;
    assign carry     = carry_reg;
    assign busy      = (state_reg == SHIFT);

endmodule

// File: tb/tb_alu_pipe.sv
// Randomised and directed bench for alu_pipe with a queue scoreboard and reference model.
module tb_alu_pipe;

    logic       Clk;
    logic       Reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       zero;
    logic       carry;
    logic       busy;

    typedef struct packed {
        logic [7:0] res;
        logic       zero;
        logic       carry;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    alu_pipe #(.WIDTH(8), .CMP_MSBS(5)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .carry     (carry),
        .busy      (busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // Reference behaviour from plain integer arithmetic on 8-bit values.
    function automatic exp_t model(int o, int x, int y);
        exp_t e;
        int   r  = x;
        int   c  = 0;
        int   k  = (y > 8) ? 8 : y;
        int   sx = (x >= 128) ? x - 256 : x;
        case (o)
            0:  begin r = x + y; c = (r > 255) ? 1 : 0; r = r % 256; end
            1:  begin c = (x >= y) ? 1 : 0; r = (x - y + 256) % 256; end
            2:  r = x ^ y;
            3:  r = $countones(x) % 2;
            4:  r = ((x / 8) == (y / 8)) ? 1 : 0;
            5:  r = (x * (1 << k)) % 256;
            6:  r = x / (1 << k);
            8:  r = x & y;
            9:  r = x | y;
            10: r = (sx >>> k) & 255;
            default: r = x;
        endcase
        e.res   = r[7:0];
        e.zero  = (r == 0);
        e.carry = c[0];
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic issue(input int o, input int x, input int y);
        int n;
        in_valid = 1'b1;
        op       = o[3:0];
        a        = x[7:0];
        b        = y[7:0];
        n        = 0;
        while (n < 100) begin
            @(negedge Clk);
            if (in_ready) break;
            n++;
        end
        if (n >= 100) begin
            chk("accept_timeout", 32'(n), 32'd0);
        end else begin
            exp_q.push_back(model(o, x, y));
            $display("issue op=%0d a=%02h b=%02h", o, x, y);
        end
        @(posedge Clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge Clk);
            #1;
            n++;
        end
    endtask

    // Monitor: every transfer pops one expected result.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (!Reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", {23'd0, result, zero}, 32'h1ff);
                end else begin
                    e = exp_q.pop_front();
                    $display("xfer result=%02h zero=%0d carry=%0d", result, zero, carry);
                    chk("result_flags", {22'd0, result, zero, carry}, {22'd0, e});
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t0;
        int o, x, y, kk;
        Reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op = '0; a = '0; b = '0;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result",    32'(result),    32'd0);
        chk("rst_flags",     {30'd0, zero, carry}, 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);

        issue(0, 8'hF0, 8'h20);
        chk("add_latency", 32'(out_valid), 32'd1);
        chk("add_result",  {23'd0, result, carry}, {23'd0, 8'h10, 1'b1});
        issue(1, 8'h05, 8'h05);
        chk("sub_zero", {30'd0, zero, carry}, 32'd3);
        issue(3, 8'h07, 8'h00);
        issue(4, 8'hF8, 8'hFF);
        issue(4, 8'hF0, 8'hF8);
        issue(8, 8'hCC, 8'hAA);
        chk("and_result", 32'(result), 32'h88);

        issue(5, 8'h81, 3);
        for (int i = 0; i < 3; i++) begin
            chk("shl_busy",     32'(busy),     32'd1);
            chk("shl_in_ready", 32'(in_ready), 32'd0);
            @(posedge Clk);
            #1;
        end
        chk("shl_done", {30'd0, out_valid, busy}, 32'd2);
        chk("shl_result", 32'(result), 32'h08);

        issue(10, 8'h80, 9);
        wait_out(n);
        chk("asr_latency", 32'(n), 32'd8);
        chk("asr_result", 32'(result), 32'hFF);

        @(posedge Clk);
        #1;
        out_ready = 1'b0;
        issue(0, 1, 1);
        for (int i = 0; i < 4; i++) begin
            chk("hold_result",   32'(result),    32'h02);
            chk("hold_valid",    32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready),  32'd0);
            @(posedge Clk);
            #1;
        end
        out_ready = 1'b1;
        issue(2, 8'h0F, 8'hFF);
        chk("release_valid", 32'(out_valid), 32'd1);
        chk("release_result", 32'(result), 32'hF0);

        t0 = cyc;
        for (int i = 0; i < 16; i++) begin
            o = $urandom_range(0, 15);
            if (o == 5 || o == 6 || o == 10) o = 9;
            issue(o, $urandom_range(0, 255), $urandom_range(0, 255));
        end
        chk("stream_cycles", 32'(cyc - t0), 32'd16);

        for (int i = 0; i < 8; i++) begin
            o  = (i % 3 == 0) ? 5 : ((i % 3 == 1) ? 6 : 10);
            x  = $urandom_range(0, 255);
            y  = (i == 0) ? 0 : ((i == 1) ? 8 : $urandom_range(0, 12));
            kk = (y > 8) ? 8 : y;
            issue(o, x, y);
            wait_out(n);
            chk("shift_latency", 32'(n), 32'(kk));
        end

        issue(6, 8'hFF, 7);
        @(posedge Clk);
        #1;
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        void'(exp_q.pop_back());
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy",      32'(busy),      32'd0);
        chk("abort_in_ready",  32'(in_ready),  32'd1);
        issue(0, 8'h12, 8'h34);
        chk("post_reset_add", {23'd0, out_valid, result}, {23'd0, 1'b1, 8'h46});

        repeat (3) @(posedge Clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
